// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller.
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Forward-mux select encodings for the MIPS32 hazard unit.
// Revision : 1.0  initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

endpackage
`default_nettype wire

// File: rtl/md_busy_tracker.sv
// Counts down the MUL/DIV latency after an issue leaves E; busy while in flight.
`default_nettype none
// ============================================================================
// Module   : md_busy_tracker
// Brief    : MUL/DIV in-flight tracker with registered busy flag.
// Revision : 1.0  initial release
// ============================================================================
module md_busy_tracker #(
    parameter int MD_LAT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic accept,
    output logic busy
);

    localparam int              c_CW  = $clog2(MD_LAT + 1);
    localparam logic [c_CW-1:0] c_LAT = c_CW'(MD_LAT);
    localparam logic [c_CW-1:0] c_ONE = c_CW'(1);

    logic [c_CW-1:0] r_mdCnt;
    logic            r_busy;

    // A re-accept while busy simply reloads the full latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdCnt <= '0;
            r_busy  <= 1'b0;
        end else if (accept) begin
            r_mdCnt <= c_LAT;
            r_busy  <= 1'b1;
        end else if (r_mdCnt != '0) begin
            r_mdCnt <= r_mdCnt - c_ONE;
            r_busy  <= (r_mdCnt != c_ONE);
        end else begin
            r_busy  <= 1'b0;
        end
    end

    assign busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for the 5-stage MIPS32 pipeline with MUL/DIV and memory-wait support.
`default_nettype none
// ============================================================================
// Module   : hazard_unit_mc
// Brief    : Forwarding, stall/flush priority, MUL/DIV busy and stall counter.
// Revision : 1.0  initial release
// ============================================================================
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regWriteE,
    input  logic              regWriteM,
    input  logic              regWriteW,
    input  logic              memToRegE,
    input  logic              memToRegM,
    input  logic              branchD,
    input  logic              jumpD,
    input  logic              mdStartE,
    input  logic              mdStartD,
    input  logic              mdReadD,
    input  logic              memReadyM,
    input  logic              stallCntClr,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeRegE,
    input  logic [REG_AW-1:0] writeRegM,
    input  logic [REG_AW-1:0] writeRegW,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushE,
    output logic              flushW,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              mdBusy,
    output logic [CNT_W-1:0]  stallCount
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    fwd_sel_t         w_fwdA;
    fwd_sel_t         w_fwdB;
    logic             w_lwStall;
    logic             w_brStall;
    logic             w_mdStall;
    logic             w_dStall;
    logic             w_mdAccept;
    logic [CNT_W-1:0] r_stallCount;

    always_comb begin
        w_fwdA = FWD_NONE;
        if (rsE != '0 && rsE == writeRegM && regWriteM)      w_fwdA = FWD_MEM;
        else if (rsE != '0 && rsE == writeRegW && regWriteW) w_fwdA = FWD_WB;
        w_fwdB = FWD_NONE;
        if (rtE != '0 && rtE == writeRegM && regWriteM)      w_fwdB = FWD_MEM;
        else if (rtE != '0 && rtE == writeRegW && regWriteW) w_fwdB = FWD_WB;
    end

    assign w_lwStall = memToRegE && (writeRegE != '0) &&
                       ((rsD == writeRegE) || (rtD == writeRegE));
    assign w_brStall = branchD &&
                       ((regWriteE && (writeRegE != '0) &&
                         ((writeRegE == rsD) || (writeRegE == rtD))) ||
                        (memToRegM && (writeRegM != '0) &&
                         ((writeRegM == rsD) || (writeRegM == rtD))));
    assign w_mdStall = mdBusy && (mdReadD || mdStartD);
    assign w_dStall  = w_lwStall || w_brStall || w_mdStall;

    // A memory wait freezes every stage; E keeps its instruction rather than bubbling.
    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushE    = 1'b0;
        flushW    = 1'b0;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        forwardAE = FWD_NONE;
        forwardBE = FWD_NONE;
        if (rst_n) begin
            forwardAD = (rsD != '0) && (rsD == writeRegM) && regWriteM;
            forwardBD = (rtD != '0) && (rtD == writeRegM) && regWriteM;
            forwardAE = w_fwdA;
            forwardBE = w_fwdB;
            if (!memReadyM) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else begin
                stallF = w_dStall;
                stallD = w_dStall;
                flushE = w_dStall || jumpD;
            end
        end
    end

    assign w_mdAccept = mdStartE && !stallE;

    md_busy_tracker #(
        .MD_LAT (MD_LAT)
    ) u_mdTracker (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (w_mdAccept),
        .busy   (mdBusy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCount <= '0;
        end else if (stallCntClr) begin
            r_stallCount <= '0;
        end else if (stallF && r_stallCount != c_CNT_MAX) begin
            r_stallCount <= r_stallCount + CNT_W'(1);
        end
    end

    assign stallCount = r_stallCount;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
// Randomized and directed checks of hazard_unit_mc against a behavioural model.
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit_mc
// Brief    : Self-checking bench for hazard_unit_mc.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_unit_mc;

    localparam int REG_AW = 5;
    localparam int MD_LAT = 8;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
    logic branchD, jumpD, mdStartE, mdStartD, mdReadD, memReadyM, stallCntClr;
    logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic stallF, stallD, stallE, stallM, flushE, flushW, forwardAD, forwardBD, mdBusy;
    logic [1:0] forwardAE, forwardBE;
    logic [CNT_W-1:0] stallCount;

    int nChecks = 0;
    int nBad    = 0;

    // Model state: edges since reset, edge index at which MUL/DIV stops being busy, perf count.
    int edgeCnt  = 0;
    int busyEnd  = 0;
    int cntModel = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memToRegE(memToRegE), .memToRegM(memToRegM),
        .branchD(branchD), .jumpD(jumpD),
        .mdStartE(mdStartE), .mdStartD(mdStartD), .mdReadD(mdReadD),
        .memReadyM(memReadyM), .stallCntClr(stallCntClr),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushE(flushE), .flushW(flushW),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mdBusy(mdBusy), .stallCount(stallCount)
    );

    task automatic checkSig(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwdExp(input logic [REG_AW-1:0] idx);
        if (idx != 0 && idx == writeRegM && regWriteM) return 2'b10;
        if (idx != 0 && idx == writeRegW && regWriteW) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        {regWriteE, regWriteM, regWriteW, memToRegE, memToRegM} = '0;
        {branchD, jumpD, mdStartE, mdStartD, mdReadD, stallCntClr} = '0;
        memReadyM = 1'b1;
        {rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW} = '0;
    endtask

    task automatic modelReset();
        edgeCnt  = 0;
        busyEnd  = 0;
        cntModel = 0;
    endtask

    // Called just after a negedge with inputs applied; checks, then advances one clock.
    task automatic step();
        logic busy, lw, br, md, d, sF, sE, fE, fW;
        #1;
        busy = (edgeCnt < busyEnd);
        lw = memToRegE && writeRegE != 0 && (rsD == writeRegE || rtD == writeRegE);
        br = branchD && ((regWriteE && writeRegE != 0 && (writeRegE == rsD || writeRegE == rtD)) ||
                         (memToRegM && writeRegM != 0 && (writeRegM == rsD || writeRegM == rtD)));
        md = busy && (mdReadD || mdStartD);
        d  = lw || br || md;
        if (!memReadyM) begin
            sF = 1; sE = 1; fE = 0; fW = 1;
        end else begin
            sF = d; sE = 0; fE = d || jumpD; fW = 0;
        end
        checkSig("mdBusy", 32'(mdBusy), 32'(busy));
        checkSig("stallCount", 32'(stallCount), 32'(cntModel));
        checkSig("stallF", 32'(stallF), 32'(sF));
        checkSig("stallD", 32'(stallD), 32'(sF));
        checkSig("stallE", 32'(stallE), 32'(sE));
        checkSig("stallM", 32'(stallM), 32'(sE));
        checkSig("flushE", 32'(flushE), 32'(fE));
        checkSig("flushW", 32'(flushW), 32'(fW));
        checkSig("forwardAE", 32'(forwardAE), 32'(fwdExp(rsE)));
        checkSig("forwardBE", 32'(forwardBE), 32'(fwdExp(rtE)));
        checkSig("forwardAD", 32'(forwardAD), 32'(rsD != 0 && rsD == writeRegM && regWriteM));
        checkSig("forwardBD", 32'(forwardBD), 32'(rtD != 0 && rtD == writeRegM && regWriteM));
        @(posedge clk);
        edgeCnt++;
        if (mdStartE && !sE) busyEnd = edgeCnt + MD_LAT;
        if (stallCntClr) cntModel = 0;
        else if (sF && cntModel < (1 << CNT_W) - 1) cntModel++;
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkSig({tag, "_stalls"}, 32'({stallF, stallD, stallE, stallM, flushE, flushW}), 32'h0);
        checkSig({tag, "_fwd"}, 32'({forwardAD, forwardBD, forwardAE, forwardBE}), 32'h0);
        checkSig({tag, "_mdBusy"}, 32'(mdBusy), 32'h0);
        checkSig({tag, "_count"}, 32'(stallCount), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        memReadyM = 1'b0;
        rsE = 5'd3; writeRegM = 5'd3; regWriteM = 1'b1;
        repeat (2) @(negedge clk);
        #1 checkAllZero("reset");
        idle();
        rst_n = 1'b1;
        modelReset();

        // Forwarding priority and the zero register
        rsE = 5'd3; writeRegM = 5'd3; regWriteM = 1; writeRegW = 5'd3; regWriteW = 1;
        #1 checkSig("fwdMemPrio", 32'(forwardAE), 32'h2);
        step();
        rsE = 5'd0;
        #1 checkSig("fwdZeroReg", 32'(forwardAE), 32'h0);
        step();
        idle();

        // Load-use stall, then none with writeRegE == 0
        memToRegE = 1; writeRegE = 5'd5; rtD = 5'd5;
        #1 checkSig("lwStall", 32'({stallF, stallD, flushE}), 32'h7);
        step();
        writeRegE = 5'd0; rtD = 5'd0;
        #1 checkSig("lwZero", 32'({stallF, stallD, flushE}), 32'h0);
        step();
        idle();

        // MUL/DIV latency with MFHI waiting in D
        mdStartE = 1;
        step();
        mdStartE = 0; mdReadD = 1;
        for (int i = 0; i < MD_LAT; i++) begin
            #1 checkSig("mdHold", 32'({mdBusy, stallD}), 32'h3);
            step();
        end
        #1 checkSig("mdRelease", 32'({mdBusy, stallD}), 32'h0);
        step();
        idle();

        // Memory wait dominates a load-use stall
        memToRegE = 1; writeRegE = 5'd5; rtD = 5'd5; memReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            #1 checkSig("memWait", 32'({stallF, stallD, stallE, stallM, flushW, flushE}), 32'h3E);
            step();
        end

        // Counter saturation and clear-over-increment
        memReadyM = 1;
        for (int i = 0; i < 20; i++) step();
        #1 checkSig("cntSat", 32'(stallCount), 32'hF);
        stallCntClr = 1;
        step();
        checkSig("cntClr", 32'(stallCount), 32'h0);
        idle();

        // Reset in the middle of a MUL/DIV
        mdStartE = 1;
        step();
        mdStartE = 0; memReadyM = 0;
        repeat (4) step();
        memToRegE = 1; writeRegE = 5'd5; rtD = 5'd5; rsE = 5'd3; writeRegM = 5'd3; regWriteM = 1;
        #1 rst_n = 1'b0;
        #1 checkAllZero("midReset");
        @(posedge clk);
        @(negedge clk);
        #1 checkAllZero("holdReset");
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        idle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            regWriteE   = 1'($urandom);
            regWriteM   = 1'($urandom);
            regWriteW   = 1'($urandom);
            memToRegE   = ($urandom_range(0, 3) == 0);
            memToRegM   = ($urandom_range(0, 3) == 0);
            branchD     = ($urandom_range(0, 3) == 0);
            jumpD       = ($urandom_range(0, 5) == 0);
            mdStartE    = ($urandom_range(0, 9) == 0);
            mdStartD    = ($urandom_range(0, 5) == 0);
            mdReadD     = ($urandom_range(0, 3) == 0);
            memReadyM   = ($urandom_range(0, 5) != 0);
            stallCntClr = ($urandom_range(0, 29) == 0);
            rsD         = REG_AW'($urandom_range(0, 3));
            rtD         = REG_AW'($urandom_range(0, 3));
            rsE         = REG_AW'($urandom_range(0, 3));
            rtE         = REG_AW'($urandom_range(0, 3));
            writeRegE   = REG_AW'($urandom_range(0, 3));
            writeRegM   = REG_AW'($urandom_range(0, 3));
            writeRegW   = REG_AW'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
`default_nettype wire
